fetch: RTL

//  Instruction-fetch stage. Owns the PC and drives a single-outstanding
//  req/ack instruction-memory port. Holds fetched words in a 2-entry prefetch

---
 rtl/fetch_if.sv | 10 +
 rtl/fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Instruction-memory port of the fetch stage: one outstanding req/ack transfer at a time.
interface fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory requests,
// buffers responses in a 2-entry prefetch FIFO and loads the IF_ID pair for decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  fetch_if.master     imem,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst
);

  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_inst_d [2];
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic       ack_fire;
  logic       pop;
  logic       push;
  logic [1:0] slot;

  always_comb begin
    ack_fire    = req_q & imem.ack;
    pop         = 1'b0;
    push        = 1'b0;
    slot        = 2'd0;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;

    if (branch_taken) begin
      cnt_d     = 2'd0;
      pc_d      = {branch_target[31:2], 2'b00};
      // A request still in flight returns stale data; mark it for discard.
      drop_d    = req_q & ~imem.ack;
      if_pc_d   = branch_target;
      if_inst_d = BUBBLE;
    end else begin
      pop  = ~HLT & (cnt_q != 2'd0);
      push = ack_fire & ~drop_q;
      if (ack_fire) begin
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      if (pop) begin
        if_pc_d        = fifo_pc_q[0];
        if_inst_d      = fifo_inst_q[0];
        fifo_pc_d[0]   = fifo_pc_q[1];
        fifo_inst_d[0] = fifo_inst_q[1];
      end else if (!HLT) begin
        if_inst_d = BUBBLE;
      end
      slot = cnt_q - {1'b0, pop};
      if (push) begin
        fifo_pc_d[slot[0]]   = addr_q;
        fifo_inst_d[slot[0]] = imem.rdata;
      end
      cnt_d = slot + {1'b0, push};
    end

    // Issue only with FIFO room left after this cycle, which reserves the response slot.
    if (req_q && !imem.ack) begin
      req_d = 1'b1;
    end else if (cnt_d < 2'd2) begin
      req_d  = 1'b1;
      addr_d = {pc_d[31:2], 2'b00};
    end else begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      pc_q        <= {RESET_PC[31:2], 2'b00};
      req_q       <= 1'b0;
      addr_q      <= {RESET_PC[31:2], 2'b00};
      drop_q      <= 1'b0;
      cnt_q       <= 2'd0;
      fifo_pc_q   <= '{default: 32'd0};
      fifo_inst_q <= '{default: 32'd0};
      if_pc_q     <= RESET_PC;
      if_inst_q   <= BUBBLE;
    end else begin
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign IF_ID_pc   = if_pc_q;
  assign IF_ID_inst = if_inst_q;

endmodule
